// File: rtl/alu_issue_seq_if.sv
// Handshake and operand bundle between decode, the ALU and writeback.
// The sequencer takes the slave side; its environment takes the master side.
interface alu_issue_seq_if #(
  parameter int WIDTH    = 32,
  parameter int RD_W     = 5,
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_f3;
  logic             req_arith;
  logic             req_shadd;
  logic             req_branch;
  logic [RD_W-1:0]  req_rd;
  logic             alu_start;
  logic [WIDTH-1:0] alu_src_a;
  logic [WIDTH-1:0] alu_src_b;
  logic [2:0]       alu_f3;
  logic             alu_arith;
  logic             alu_shadd;
  logic             alu_branch;
  logic [WIDTH-1:0] alu_out;
  logic             alu_done;
  logic             wb_valid;
  logic             wb_ready;
  logic [WIDTH-1:0] wb_data;
  logic [RD_W-1:0]  wb_rd;
  logic             wb_is_branch;
  logic             wb_br_taken;
  logic             wb_err;
  logic [CNT_W-1:0] wb_lat;

  modport slave (
    input  flush, req_valid, req_a, req_b, req_f3,
    input  req_arith, req_shadd, req_branch, req_rd,
    input  alu_out, alu_done, wb_ready,
    output req_ready, alu_start, alu_src_a, alu_src_b,
    output alu_f3, alu_arith, alu_shadd, alu_branch,
    output wb_valid, wb_data, wb_rd, wb_is_branch,
    output wb_br_taken, wb_err, wb_lat
  );

  modport master (
    output flush, req_valid, req_a, req_b, req_f3,
    output req_arith, req_shadd, req_branch, req_rd,
    output alu_out, alu_done, wb_ready,
    input  req_ready, alu_start, alu_src_a, alu_src_b,
    input  alu_f3, alu_arith, alu_shadd, alu_branch,
    input  wb_valid, wb_data, wb_rd, wb_is_branch,
    input  wb_br_taken, wb_err, wb_lat
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Requester-side sequencer for a multi-cycle ALU start/done port.
// One op in flight: accept, start, wait (with watchdog), respond.
module alu_issue_seq #(
  parameter int WIDTH    = 32,
  parameter int RD_W     = 5,
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input logic           clk,
  input logic           rst,
  alu_issue_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX_WAIT);

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             wb_hs;
  logic             done_cap;
  logic             wd_hit;
  logic [CNT_W-1:0] cnt;
  logic [RD_W-1:0]  rd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f3_q;
  logic             arith_q;
  logic             shadd_q;
  logic             branch_q;
  logic [WIDTH-1:0] data_q;
  logic             taken_q;
  logic             err_q;
  logic [CNT_W-1:0] lat_q;

  // Flush blocks a new request in the same cycle.
  assign bus.req_ready = (state == IDLE) && !bus.flush;
  assign accept   = bus.req_valid && bus.req_ready;
  assign wb_hs    = (state == RESP) && bus.wb_ready && !bus.flush;
  assign done_cap = (state == WAIT) && bus.alu_done;
  // Done wins over the watchdog when both land together.
  assign wd_hit   = (state == WAIT) && !bus.alu_done && (cnt == CMAX);

  assign bus.alu_start    = (state == START);
  assign bus.wb_valid     = (state == RESP);
  assign bus.alu_src_a    = a_q;
  assign bus.alu_src_b    = b_q;
  assign bus.alu_f3       = f3_q;
  assign bus.alu_arith    = arith_q;
  assign bus.alu_shadd    = shadd_q;
  assign bus.alu_branch   = branch_q;
  assign bus.wb_data      = data_q;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_is_branch = branch_q;
  assign bus.wb_br_taken  = taken_q;
  assign bus.wb_err       = err_q;
  assign bus.wb_lat       = lat_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = START;
      START: state_nx = WAIT;
      WAIT:  if (done_cap || wd_hit) state_nx = RESP;
      RESP:  if (wb_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  // Operand and control capture at request accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      arith_q  <= 1'b0;
      shadd_q  <= 1'b0;
      branch_q <= 1'b0;
      rd_q     <= '0;
    end else if (accept) begin
      a_q      <= bus.req_a;
      b_q      <= bus.req_b;
      f3_q     <= bus.req_f3;
      arith_q  <= bus.req_arith;
      shadd_q  <= bus.req_shadd;
      branch_q <= bus.req_branch;
      rd_q     <= bus.req_rd;
    end
  end

  // Saturating count of WAIT cycles without done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == WAIT && !bus.alu_done && cnt != CMAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Result capture on done or watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else if (bus.flush) begin
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= 1'b0;
    end else if (done_cap) begin
      data_q  <= bus.alu_out;
      taken_q <= branch_q & bus.alu_out[0];
      err_q   <= 1'b0;
      lat_q   <= cnt;
    end else if (wd_hit) begin
      data_q  <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b1;
      lat_q   <= CMAX;
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq.
// Hand-computed expectations; scripted ALU responder.
module tb_alu_issue_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  alu_issue_seq_if #(.WIDTH(32), .RD_W(5), .MAX_WAIT(40)) bus ();

  alu_issue_seq #(
    .WIDTH(32),
    .RD_W(5),
    .MAX_WAIT(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_req(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f3,
    input  logic        br,
    input  logic [4:0]  rd,
    output logic        rdy
  );
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_f3     = f3;
    bus.req_branch = br;
    bus.req_rd     = rd;
    #1 rdy = bus.req_ready;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic alu_respond(
    input  int          k,
    input  logic        fire,
    input  logic [31:0] res,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [2:0]  ef3,
    input  logic        ebr,
    output int          starts,
    output int          bad,
    output int          early
  );
    starts = 0;
    bad    = 0;
    early  = 0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (bus.alu_start) starts++;
      if (bus.alu_src_a !== ea || bus.alu_src_b !== eb) bad++;
      if (bus.alu_f3 !== ef3 || bus.alu_branch !== ebr) bad++;
      if (bus.wb_valid) early++;
      @(posedge clk);
      #1;
    end
    bus.alu_done = fire;
    bus.alu_out  = res;
    @(negedge clk);
    if (bus.alu_start) starts++;
    if (bus.alu_src_a !== ea || bus.alu_src_b !== eb) bad++;
    if (bus.wb_valid) early++;
    @(posedge clk);
    #1;
    bus.alu_done = 1'b0;
    bus.alu_out  = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready got=%b exp=1", bus.req_ready);
    end
    n_cmp++;
    if ({bus.wb_valid, bus.alu_start, bus.wb_err} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_flags got=%b exp=000",
               {bus.wb_valid, bus.alu_start, bus.wb_err});
    end
    n_cmp++;
    if (bus.alu_src_a !== 32'd0 || bus.wb_data !== 32'd0 ||
        bus.wb_lat !== 6'd0) begin
      n_bad++;
      $display("FAIL rst_regs got a=%h d=%h l=%0d exp=0",
               bus.alu_src_a, bus.wb_data, bus.wb_lat);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic rdy;
    int   st, bd, ea;
    send_req(32'd5, 32'd7, 3'd0, 1'b0, 5'd3, rdy);
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL add_ready got=%b exp=1", rdy);
    end
    alu_respond(1, 1'b1, 32'd12, 32'd5, 32'd7, 3'd0, 1'b0, st, bd, ea);
    n_cmp++;
    if (st !== 1 || bd !== 0 || ea !== 0) begin
      n_bad++;
      $display("FAIL add_seq got st=%0d bad=%0d early=%0d exp=1/0/0",
               st, bd, ea);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd12) begin
      n_bad++;
      $display("FAIL add_wb got v=%b d=%0d exp v=1 d=12",
               bus.wb_valid, bus.wb_data);
    end
    n_cmp++;
    if (bus.wb_lat !== 6'd0 || bus.wb_err !== 1'b0 ||
        bus.wb_rd !== 5'd3) begin
      n_bad++;
      $display("FAIL add_meta got l=%0d e=%b rd=%0d exp 0/0/3",
               bus.wb_lat, bus.wb_err, bus.wb_rd);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL add_idle got v=%b r=%b exp v=0 r=1",
               bus.wb_valid, bus.req_ready);
    end
  endtask

  task automatic test_sll;
    logic rdy;
    int   st, bd, ea;
    send_req(32'd1, 32'd31, 3'd1, 1'b0, 5'd8, rdy);
    alu_respond(32, 1'b1, 32'h8000_0000, 32'd1, 32'd31, 3'd1, 1'b0,
                st, bd, ea);
    n_cmp++;
    if (st !== 1 || bd !== 0 || ea !== 0) begin
      n_bad++;
      $display("FAIL sll_hold got st=%0d bad=%0d early=%0d exp=1/0/0",
               st, bd, ea);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL sll_wb got v=%b d=%h exp v=1 d=80000000",
               bus.wb_valid, bus.wb_data);
    end
    n_cmp++;
    if (bus.wb_lat !== 6'd31) begin
      n_bad++;
      $display("FAIL sll_lat got=%0d exp=31", bus.wb_lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_branch;
    logic [31:0] res [3];
    logic        br  [3];
    logic        tk  [3];
    logic        rdy;
    int          st, bd, ea;
    res[0] = 32'd1; br[0] = 1'b1; tk[0] = 1'b1;
    res[1] = 32'd0; br[1] = 1'b1; tk[1] = 1'b0;
    res[2] = 32'd1; br[2] = 1'b0; tk[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_req(32'd9, 32'd9, 3'd0, br[i], 5'd1, rdy);
      alu_respond(2, 1'b1, res[i], 32'd9, 32'd9, 3'd0, br[i],
                  st, bd, ea);
      @(negedge clk);
      n_cmp++;
      if (bus.wb_is_branch !== br[i] || bus.wb_br_taken !== tk[i]) begin
        n_bad++;
        $display("FAIL br%0d got isb=%b tk=%b exp isb=%b tk=%b", i,
                 bus.wb_is_branch, bus.wb_br_taken, br[i], tk[i]);
      end
      n_cmp++;
      if (bus.wb_lat !== 6'd1 || bus.wb_data !== res[i]) begin
        n_bad++;
        $display("FAIL br%0d_wb got l=%0d d=%0d exp l=1 d=%0d", i,
                 bus.wb_lat, bus.wb_data, res[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_watchdog;
    logic rdy;
    int   st, bd, ea;
    send_req(32'd2, 32'd3, 3'd0, 1'b0, 5'd5, rdy);
    alu_respond(41, 1'b0, 32'hDEAD, 32'd2, 32'd3, 3'd0, 1'b0,
                st, bd, ea);
    n_cmp++;
    if (ea !== 0) begin
      n_bad++;
      $display("FAIL wd_early got=%0d exp=0", ea);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.wb_err !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_err got v=%b e=%b exp v=1 e=1",
               bus.wb_valid, bus.wb_err);
    end
    n_cmp++;
    if (bus.wb_data !== 32'd0 || bus.wb_lat !== 6'd40) begin
      n_bad++;
      $display("FAIL wd_val got d=%h l=%0d exp d=0 l=40",
               bus.wb_data, bus.wb_lat);
    end
    @(posedge clk);
    #1;
    send_req(32'd2, 32'd3, 3'd0, 1'b0, 5'd5, rdy);
    alu_respond(41, 1'b1, 32'h1234, 32'd2, 32'd3, 3'd0, 1'b0,
                st, bd, ea);
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.wb_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_edge got v=%b e=%b exp v=1 e=0",
               bus.wb_valid, bus.wb_err);
    end
    n_cmp++;
    if (bus.wb_data !== 32'h1234 || bus.wb_lat !== 6'd40) begin
      n_bad++;
      $display("FAIL wd_edge_val got d=%h l=%0d exp d=1234 l=40",
               bus.wb_data, bus.wb_lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic rdy;
    int   st, bd, ea;
    bus.wb_ready = 1'b0;
    send_req(32'h10, 32'h20, 3'd0, 1'b0, 5'd7, rdy);
    alu_respond(1, 1'b1, 32'h30, 32'h10, 32'h20, 3'd0, 1'b0,
                st, bd, ea);
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h55;
    bus.req_b     = 32'h66;
    bus.req_rd    = 5'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h30 ||
          bus.wb_rd !== 5'd7 || bus.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall%0d got v=%b d=%h rd=%0d r=%b exp 1/30/7/0",
                 i, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.req_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.wb_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle got v=%b r=%b exp v=0 r=1",
               bus.wb_valid, bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    alu_respond(1, 1'b1, 32'hBB, 32'h55, 32'h66, 3'd0, 1'b0,
                st, bd, ea);
    n_cmp++;
    if (st !== 1 || bd !== 0) begin
      n_bad++;
      $display("FAIL b2b_start got st=%0d bad=%0d exp 1/0", st, bd);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.wb_data !== 32'hBB || bus.wb_rd !== 5'd9) begin
      n_bad++;
      $display("FAIL b2b_wb got d=%h rd=%0d exp d=bb rd=9",
               bus.wb_data, bus.wb_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_reset;
    logic rdy;
    int   st, bd, ea;
    send_req(32'd3, 32'd4, 3'd0, 1'b0, 5'd2, rdy);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_wait got r=%b v=%b exp r=0 v=0",
               bus.req_ready, bus.wb_valid);
    end
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.alu_done = 1'b1;
    bus.alu_out  = 32'h77;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.alu_start !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_idle got r=%b s=%b exp r=1 s=0",
               bus.req_ready, bus.alu_start);
    end
    @(posedge clk);
    #1 bus.alu_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_late got v=%b exp=0", bus.wb_valid);
    end
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_req got r=%b exp=0", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.alu_start !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fl_noacc got s=%b r=%b exp s=0 r=1",
               bus.alu_start, bus.req_ready);
    end
    bus.wb_ready = 1'b0;
    send_req(32'hF0, 32'h0F, 3'd0, 1'b0, 5'd4, rdy);
    alu_respond(1, 1'b1, 32'hFF, 32'hF0, 32'h0F, 3'd0, 1'b0,
                st, bd, ea);
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hFF) begin
      n_bad++;
      $display("FAIL rr_resp got v=%b d=%h exp v=1 d=ff",
               bus.wb_valid, bus.wb_data);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rr_async got v=%b r=%b exp v=0 r=1",
               bus.wb_valid, bus.req_ready);
    end
    n_cmp++;
    if (bus.wb_data !== 32'd0 || bus.alu_src_a !== 32'd0 ||
        bus.wb_rd !== 5'd0 || bus.wb_lat !== 6'd0) begin
      n_bad++;
      $display("FAIL rr_regs got d=%h a=%h rd=%0d l=%0d exp 0",
               bus.wb_data, bus.alu_src_a, bus.wb_rd, bus.wb_lat);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.wb_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rr_after got v=%b r=%b exp v=0 r=1",
               bus.wb_valid, bus.req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_f3     = '0;
    bus.req_arith  = 1'b0;
    bus.req_shadd  = 1'b0;
    bus.req_branch = 1'b0;
    bus.req_rd     = '0;
    bus.alu_out    = '0;
    bus.alu_done   = 1'b0;
    bus.wb_ready   = 1'b1;
    test_reset();
    test_add();
    test_sll();
    test_branch();
    test_watchdog();
    test_back_to_back();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
